// File: rtl/sdram_arb_n_if.sv
// sdram_ctrl_if: command/response handshake between SDRAM clients and the controller.
// wr is a byte-enable mask; any set bit marks a write command.
interface sdram_ctrl_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  localparam int BE_W = DATA_W / 8;

  logic              rd;
  logic [BE_W-1:0]   wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic              rdy;
  logic              rvalid;
  logic              wvalid;
  logic              error;
  logic [DATA_W-1:0] read_data;

  modport man (output rd, wr, addr, write_data,
               input  rdy, rvalid, wvalid, error, read_data);
  modport sub (input  rd, wr, addr, write_data,
               output rdy, rvalid, wvalid, error, read_data);
endinterface

// File: rtl/sdram_arb_n.sv
// sdram_arb_n: N-port SDRAM command arbiter with an in-order owner FIFO for response routing.
// Build option: define SDRAM_ARB_RR_EN for round-robin arbitration; fixed priority otherwise.
module sdram_arb_n #(
  parameter int NPORTS = 2,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
) (
  input  logic      clk,
  input  logic      rst,
  sdram_ctrl_if.man ctrl_if,
  sdram_ctrl_if.sub port_if [NPORTS],
  output logic      stray_rsp
);
  localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BE_W  = DATA_W / 8;

  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] p_rd;
  logic [BE_W-1:0]   p_wr    [NPORTS];
  logic [ADDR_W-1:0] p_addr  [NPORTS];
  logic [DATA_W-1:0] p_wdata [NPORTS];

  logic [IDX_W-1:0] grant;
  logic             grant_valid;
  logic             full;
  logic             empty;
  logic             accept;
  logic             rsp;
  logic             pop;
  logic [IDX_W-1:0] head;

  logic [IDX_W-1:0] owner_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    logic sel;
    assign p_rd[i]    = port_if[i].rd;
    assign p_wr[i]    = port_if[i].wr;
    assign p_addr[i]  = port_if[i].addr;
    assign p_wdata[i] = port_if[i].write_data;
    assign req[i]     = port_if[i].rd | (|port_if[i].wr);

    // Responses go only to the port that owns the FIFO head.
    assign sel                 = pop && (head == IDX_W'(i));
    assign port_if[i].rdy       = accept && (grant == IDX_W'(i));
    assign port_if[i].rvalid    = sel & ctrl_if.rvalid;
    assign port_if[i].wvalid    = sel & ctrl_if.wvalid;
    assign port_if[i].error     = sel & ctrl_if.error;
    assign port_if[i].read_data = sel ? ctrl_if.read_data : '0;
  end

`ifdef SDRAM_ARB_RR_EN
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    cand        = '0;
    // Search starts one past the most recently accepted port.
    for (int k = 1; k <= NPORTS; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NPORTS);
      if (!grant_valid && req[cand]) begin
        grant       = cand;
        grant_valid = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = accept ? grant : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= IDX_W'(NPORTS - 1);
    else     last_q <= last_d;
  end
`else
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant       = IDX_W'(i);
        grant_valid = 1'b1;
      end
    end
  end
`endif

  assign ctrl_if.rd         = grant_valid & p_rd[grant];
  assign ctrl_if.wr         = grant_valid ? p_wr[grant]    : '0;
  assign ctrl_if.addr       = grant_valid ? p_addr[grant]  : '0;
  assign ctrl_if.write_data = grant_valid ? p_wdata[grant] : '0;

  // full is the pre-pop flag, so a full FIFO never pushes in its pop cycle.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign accept    = ctrl_if.rdy & ~full & grant_valid;
  assign rsp       = ctrl_if.rvalid | ctrl_if.wvalid | ctrl_if.error;
  assign pop       = rsp & ~empty;
  assign stray_rsp = rsp & empty;
  assign head      = owner_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) owner_q[wr_ptr_q] <= grant;
  end
endmodule

// File: tb/tb_sdram_arb_n.sv
// Directed self-checking bench for sdram_arb_n with four ports and a four-deep owner FIFO.
module tb_sdram_arb_n;
  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stray;

  logic [NP-1:0] b_rd;
  logic [1:0]    b_wr   [NP];
  logic [23:0]   b_addr [NP];
  logic [15:0]   b_wd   [NP];
  logic [NP-1:0] o_rdy, o_rv, o_wv, o_err;
  logic [15:0]   o_rdata [NP];

  logic        c_rdy, c_rv, c_wv, c_err;
  logic [15:0] c_rdata;
  logic        c_out_rd;
  logic [1:0]  c_out_wr;
  logic [23:0] c_out_addr;

  int checks = 0;
  int errors = 0;

  sdram_ctrl_if #(.ADDR_W(24), .DATA_W(16)) ctrl ();
  sdram_ctrl_if #(.ADDR_W(24), .DATA_W(16)) pif [NP] ();

  assign ctrl.rdy       = c_rdy;
  assign ctrl.rvalid    = c_rv;
  assign ctrl.wvalid    = c_wv;
  assign ctrl.error     = c_err;
  assign ctrl.read_data = c_rdata;
  assign c_out_rd       = ctrl.rd;
  assign c_out_wr       = ctrl.wr;
  assign c_out_addr     = ctrl.addr;

  for (genvar i = 0; i < NP; i++) begin : g_map
    assign pif[i].rd         = b_rd[i];
    assign pif[i].wr         = b_wr[i];
    assign pif[i].addr       = b_addr[i];
    assign pif[i].write_data = b_wd[i];
    assign o_rdy[i]          = pif[i].rdy;
    assign o_rv[i]           = pif[i].rvalid;
    assign o_wv[i]           = pif[i].wvalid;
    assign o_err[i]          = pif[i].error;
    assign o_rdata[i]        = pif[i].read_data;
  end

  sdram_arb_n #(.NPORTS(NP), .DEPTH(4), .ADDR_W(24), .DATA_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl_if   (ctrl),
    .port_if   (pif),
    .stray_rsp (stray)
  );

  always #5 clk = ~clk;

  task automatic idle();
    b_rd = '0;
    for (int i = 0; i < NP; i++) begin
      b_wr[i]   = '0;
      b_addr[i] = 24'h100 * (i + 1);
      b_wd[i]   = 16'h0;
    end
    c_rdy = 1'b0; c_rv = 1'b0; c_wv = 1'b0; c_err = 1'b0; c_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (o_rdy !== 4'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0000", o_rdy); end
    checks++; if ((o_rv | o_wv | o_err) !== 4'b0) begin errors++; $display("FAIL reset_rsp: got %b expected 0000", o_rv | o_wv | o_err); end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL reset_stray: got %b expected 0", stray); end
    checks++; if (dut.count_q !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", dut.count_q); end
    checks++; if ({c_out_rd, c_out_wr, c_out_addr} !== 27'h0) begin errors++; $display("FAIL reset_ctrl_cmd: got %h expected 0", {c_out_rd, c_out_wr, c_out_addr}); end
    c_rdy = 1'b1;
    #1;
    checks++; if (o_rdy !== 4'b0) begin errors++; $display("FAIL noreq_rdy: got %b expected 0000", o_rdy); end
  endtask

  // Continuous reads with rvalid returned one cycle after each accept.
  task automatic test_arbitration();
    logic [3:0] masks [2];
    int         exp_idx [2][6];
    logic [3:0] exp_g, prev_g;
    masks[0] = 4'b0011;
    masks[1] = 4'b1111;
`ifdef SDRAM_ARB_RR_EN
    exp_idx[0] = '{0, 1, 0, 1, 0, 1};
    exp_idx[1] = '{0, 1, 2, 3, 0, 1};
`else
    exp_idx[0] = '{0, 0, 0, 0, 0, 0};
    exp_idx[1] = '{0, 0, 0, 0, 0, 0};
`endif
    for (int s = 0; s < 2; s++) begin
      do_reset();
      prev_g = '0;
      for (int k = 0; k < 6; k++) begin
        if (k > 0) @(negedge clk);
        b_rd    = masks[s];
        c_rdy   = 1'b1;
        c_rv    = (k > 0);
        c_rdata = 16'h1000 + 16'(k);
        #1;
        exp_g = 4'b0001 << exp_idx[s][k];
        checks++; if (o_rdy !== exp_g) begin errors++; $display("FAIL arb_rdy s%0d k%0d: got %b expected %b", s, k, o_rdy, exp_g); end
        checks++; if (c_out_addr !== 24'h100 * (exp_idx[s][k] + 1)) begin errors++; $display("FAIL arb_addr s%0d k%0d: got %h expected %h", s, k, c_out_addr, 24'h100 * (exp_idx[s][k] + 1)); end
        if (k > 0) begin
          checks++; if (o_rv !== prev_g) begin errors++; $display("FAIL arb_rvalid s%0d k%0d: got %b expected %b", s, k, o_rv, prev_g); end
          checks++; if (stray !== 1'b0) begin errors++; $display("FAIL arb_stray s%0d k%0d: got %b expected 0", s, k, stray); end
`ifdef SDRAM_ARB_RR_EN
          checks++; if (dut.last_q !== 2'(exp_idx[s][k-1])) begin errors++; $display("FAIL rr_last s%0d k%0d: got %0d expected %0d", s, k, dut.last_q, exp_idx[s][k-1]); end
`endif
        end
        prev_g = exp_g;
      end
      @(negedge clk);
      b_rd = '0;
      c_rv = 1'b1;
      #1;
      checks++; if (o_rv !== prev_g) begin errors++; $display("FAIL arb_drain s%0d: got %b expected %b", s, o_rv, prev_g); end
    end
  endtask

  task automatic test_full();
    int seq [4];
    seq = '{2, 0, 1, 3};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      for (int i = 0; i < NP; i++) b_wr[i] = '0;
      b_wr[seq[k]] = 2'b11;
      c_rdy = 1'b1;
      #1;
      checks++; if (o_rdy !== (4'b0001 << seq[k])) begin errors++; $display("FAIL full_push k%0d: got %b expected %b", k, o_rdy, 4'b0001 << seq[k]); end
    end
    @(negedge clk);
    #1;
    checks++; if (dut.count_q !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", dut.count_q); end
    checks++; if (o_rdy !== 4'b0) begin errors++; $display("FAIL full_rdy: got %b expected 0000", o_rdy); end
    @(negedge clk);
    c_wv = 1'b1;
    #1;
    checks++; if (o_wv !== 4'b0100) begin errors++; $display("FAIL full_wvalid: got %b expected 0100", o_wv); end
    checks++; if (o_rdy !== 4'b0) begin errors++; $display("FAIL full_pop_rdy: got %b expected 0000", o_rdy); end
    @(negedge clk);
    c_wv = 1'b0;
    #1;
    checks++; if (o_rdy !== 4'b1000) begin errors++; $display("FAIL full_rdy_back: got %b expected 1000", o_rdy); end
    checks++; if (o_wv !== 4'b0) begin errors++; $display("FAIL full_wv_clear: got %b expected 0000", o_wv); end
  endtask

  task automatic test_interleave();
    int         own [3];
    logic [15:0] exp_d;
    own = '{2, 0, 1};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      b_rd  = 4'b0001 << own[k];
      c_rdy = 1'b1;
      #1;
      checks++; if (o_rdy !== (4'b0001 << own[k])) begin errors++; $display("FAIL il_push k%0d: got %b expected %b", k, o_rdy, 4'b0001 << own[k]); end
    end
    @(negedge clk);
    b_rd = '0; c_rv = 1'b1; c_rdata = 16'hA5A5;
    #1;
    checks++; if (o_rv !== 4'b0100) begin errors++; $display("FAIL il_rvalid: got %b expected 0100", o_rv); end
    checks++; if ((o_wv | o_err) !== 4'b0) begin errors++; $display("FAIL il_rv_others: got %b expected 0000", o_wv | o_err); end
    for (int i = 0; i < NP; i++) begin
      exp_d = (i == 2) ? 16'hA5A5 : 16'h0;
      checks++; if (o_rdata[i] !== exp_d) begin errors++; $display("FAIL il_rdata p%0d: got %h expected %h", i, o_rdata[i], exp_d); end
    end
    @(negedge clk);
    c_rv = 1'b0; c_err = 1'b1; c_rdata = 16'h1234;
    #1;
    checks++; if (o_err !== 4'b0001) begin errors++; $display("FAIL il_error: got %b expected 0001", o_err); end
    checks++; if ((o_rv | o_wv) !== 4'b0) begin errors++; $display("FAIL il_err_only: got %b expected 0000", o_rv | o_wv); end
    for (int i = 0; i < NP; i++) begin
      exp_d = (i == 0) ? 16'h1234 : 16'h0;
      checks++; if (o_rdata[i] !== exp_d) begin errors++; $display("FAIL il_err_rdata p%0d: got %h expected %h", i, o_rdata[i], exp_d); end
    end
    @(negedge clk);
    c_err = 1'b0; c_wv = 1'b1; c_rdata = '0;
    #1;
    checks++; if (o_wv !== 4'b0010) begin errors++; $display("FAIL il_wvalid: got %b expected 0010", o_wv); end
    checks++; if (o_err !== 4'b0) begin errors++; $display("FAIL il_wv_err: got %b expected 0000", o_err); end
  endtask

  task automatic test_stray();
    do_reset();
    c_rv = 1'b1;
    #1;
    checks++; if (stray !== 1'b1) begin errors++; $display("FAIL stray_pulse: got %b expected 1", stray); end
    checks++; if (o_rv !== 4'b0) begin errors++; $display("FAIL stray_rvalid: got %b expected 0000", o_rv); end
    @(negedge clk);
    c_rv = 1'b0;
    #1;
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL stray_clear: got %b expected 0", stray); end
    @(negedge clk);
    b_rd = 4'b0010; c_rdy = 1'b1; c_rv = 1'b1;
    #1;
    checks++; if (stray !== 1'b1) begin errors++; $display("FAIL stray_same_cycle: got %b expected 1", stray); end
    checks++; if (o_rdy !== 4'b0010) begin errors++; $display("FAIL stray_accept: got %b expected 0010", o_rdy); end
    checks++; if (o_rv !== 4'b0) begin errors++; $display("FAIL stray_same_rv: got %b expected 0000", o_rv); end
    @(negedge clk);
    b_rd = '0;
    #1;
    checks++; if (o_rv !== 4'b0010) begin errors++; $display("FAIL stray_next_route: got %b expected 0010", o_rv); end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL stray_next_flag: got %b expected 0", stray); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    b_rd = 4'b0001; c_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    b_rd = '0;
    rst  = 1'b1;
    #1;
    checks++; if (dut.count_q !== 3'd2) begin errors++; $display("FAIL mid_pre_count: got %0d expected 2", dut.count_q); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (dut.count_q !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", dut.count_q); end
    checks++; if ((o_rdy | o_rv | o_wv | o_err) !== 4'b0) begin errors++; $display("FAIL mid_outputs: got %b expected 0000", o_rdy | o_rv | o_wv | o_err); end
    c_rv = 1'b1;
    #1;
    checks++; if (stray !== 1'b1) begin errors++; $display("FAIL mid_stray: got %b expected 1", stray); end
    checks++; if (o_rv !== 4'b0) begin errors++; $display("FAIL mid_rvalid: got %b expected 0000", o_rv); end
  endtask

  initial begin
    idle();
    test_reset();
    test_arbitration();
    test_full();
    test_interleave();
    test_stray();
    test_reset_mid();
    @(negedge clk);
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
